// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/acknowledge bus
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  modport master(output dm_req, dm_we, dm_be, dm_addr, dm_wdata, input dm_rdata, dm_ack);
  modport slave(input dm_req, dm_we, dm_be, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with stall, alignment and load extraction
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      memreadM,
  input  logic                      memwriteM,
  input  logic [1:0]                memsizeM,
  input  logic                      memsignM,
  input  logic                      regwriteM,
  input  logic [31:0]               ALUoutM,
  input  logic [31:0]               writedataM,
  output logic [31:0]               MemoutM,
  output logic                      regwriteMo,
  output logic                      stallM,
  output logic                      alignerr,
  output logic                      buserr,
  mem_access_unit_if.master         dm
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_data;
  logic [1:0] r_size, r_lo;
  logic r_sign, r_rd, r_buserr;
  logic w_access, w_word, w_half, w_mis, w_start, w_to;
  logic [31:0] w_sh, w_ext;
  assign w_access = memreadM | memwriteM;
  assign w_word = memsizeM[1];
  assign w_half = memsizeM == 2'b01;
  assign w_mis = (w_half & ALUoutM[0]) | (w_word & |ALUoutM[1:0]);
  assign w_start = (r_state == IDLE) & w_access & ~w_mis;
  assign w_to = (TIMEOUT != 0) && (r_cnt == LAST);
  // load lanes are pulled down to bit 0 so byte/half extraction is a fixed slice
  assign w_sh = dm.dm_rdata >> {r_lo, 3'b000};
  assign w_ext = r_size[1] ? dm.dm_rdata :
                 r_size[0] ? {{16{r_sign & w_sh[15]}}, w_sh[15:0]} :
                             {{24{r_sign & w_sh[7]}}, w_sh[7:0]};
  // state register
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state and pipeline-facing outputs
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_start ? WAIT : IDLE) :
             r_state == WAIT ? ((dm.dm_ack | w_to) ? DONE : WAIT) : IDLE;
    stallM = w_start | (r_state == WAIT);
    alignerr = (r_state == IDLE) & w_access & w_mis;
    regwriteMo = regwriteM & ~stallM & ~alignerr;
    MemoutM = r_state == DONE ? r_data : 32'd0;
    buserr = r_buserr;
  end
  // bus request, captured access attributes, timeout counter and load data
  always_ff @(posedge clk)
    if (!rst_n) begin
      dm.dm_req <= 1'b0;
      dm.dm_we <= 1'b0;
      dm.dm_be <= 4'd0;
      dm.dm_addr <= 32'd0;
      dm.dm_wdata <= 32'd0;
      r_data <= 32'd0;
      r_cnt <= '0;
      r_buserr <= 1'b0;
      r_size <= 2'd0;
      r_lo <= 2'd0;
      r_sign <= 1'b0;
      r_rd <= 1'b0;
    end else begin
      r_buserr <= 1'b0;
      if (w_start) begin
        dm.dm_req <= 1'b1;
        dm.dm_we <= ~memreadM;
        dm.dm_be <= memreadM ? 4'b1111 : w_word ? 4'b1111 :
                    w_half ? (ALUoutM[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ALUoutM[1:0];
        dm.dm_addr <= {ALUoutM[31:2], 2'b00};
        dm.dm_wdata <= w_word ? writedataM : w_half ? {2{writedataM[15:0]}} : {4{writedataM[7:0]}};
        r_size <= memsizeM;
        r_sign <= memsignM;
        r_lo <= ALUoutM[1:0];
        r_rd <= memreadM;
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        if (dm.dm_ack) begin
          dm.dm_req <= 1'b0;
          r_data <= r_rd ? w_ext : 32'd0;
        end else if (w_to) begin
          dm.dm_req <= 1'b0;
          r_data <= 32'd0;
          r_buserr <= 1'b1;
        end else r_cnt <= r_cnt + CW'(1);
      end
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the five-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. It turns load/store control from EX/MEM into a request/acknowledge transaction on the data-memory port, stalls the pipeline until the memory acknowledges, and aligns and extends load data. The result drives the MEM/WB `MemoutM` input.

## Interface
- `TIMEOUT`, default 255: maximum cycles in WAIT before the access is aborted; 0 disables the timeout.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `memreadM`  in  1  load in MEM.
- `memwriteM`  in  1  store in MEM; `memreadM` takes priority if both are set.
- `memsizeM`  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `memsignM`  in  1  1 = sign-extend loads, 0 = zero-extend.
- `regwriteM`  in  1  register-write flag from EX/MEM.
- `ALUoutM`  in  32  byte address.
- `writedataM`  in  32  store data in the low bits.
- `MemoutM`  out  32  aligned and extended load data; 0 for stores and non-memory instructions.
- `regwriteMo`  out  1  `regwriteM` gated off while `stallM` is high and on alignment error; feeds MEM/WB.
- `stallM`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- `alignerr`  out  1  one-cycle pulse on a misaligned access.
- `buserr`  out  1  one-cycle pulse on timeout.
- `dm_req`  out  1  memory request (registered).
- `dm_we`  out  1  1 = write.
- `dm_be`  out  4  byte enables (registered).
- `dm_addr`  out  32  word address, with `[1:0]` forced to 00.
- `dm_wdata`  out  32  lane-replicated write data.
- `dm_rdata`  in  32  read data; valid when `dm_ack` = 1.
- `dm_ack`  in  1  transaction complete, sampled on the rising edge of `clk`.

## Operation
- Access condition: `access` = `memreadM | memwriteM`.
- Misalignment:
  - Half-word access with `ALUoutM[0]` = 1 is misaligned.
  - Word access with `ALUoutM[1:0]` ≠ 00 is misaligned.
  - On misalignment: no transaction, `alignerr` = 1 for that cycle, `stallM` = 0, `regwriteMo` = 0, `MemoutM` = 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - For an aligned access: `stallM` = 1 (combinational). Next state WAIT. Register `dm_req` = 1, `dm_we`, `dm_be`, `dm_addr`, `dm_wdata`, size, sign and `ALUoutM[1:0]`. Clear the timeout counter.
  - With no access: `MemoutM` = 0 and `regwriteMo` = `regwriteM`.
  - `dm_ack` is ignored in IDLE.
- WAIT:
  - `stallM` = 1; `dm_req` and the other `dm_*` outputs are held stable.
  - On `dm_ack`: capture the extracted data into the data register, drop `dm_req`, go to DONE.
  - On timeout (counter reaches `TIMEOUT` with no ack): data register = 0, drop `dm_req`, `buserr` pulses on the transition cycle, go to DONE.
- DONE:
  - `stallM` = 0; `MemoutM` = data register; `regwriteMo` = `regwriteM`.
  - Next state IDLE unconditionally. The frozen instruction advances at this edge and MEM/WB captures the result.
- Lane mapping is little-endian: byte k = `dm_rdata[8k+7:8k]`, where k = `addr[1:0]`; half h = `dm_rdata[16h+15:16h]`, where h = `addr[1]`.
- Store enables and data:
  - Byte: `dm_be` = 1<<k, `dm_wdata` = `{4{writedataM[7:0]}}`.
  - Half: `dm_be` = 0011 or 1100, `dm_wdata` = `{2{writedataM[15:0]}}`.
  - Word: `dm_be` = 1111, `dm_wdata` = `writedataM`.
- Load enables: `dm_be` = 1111 for all loads; extraction is done locally.
- Store completion: the data register is written as 0.

## Timing
- Reset values: state IDLE; `dm_req` 0, `dm_we` 0, `dm_be` 0, `dm_addr` 0, `dm_wdata` 0; data register 0; timeout counter 0; `buserr` 0.
  - Combinational outputs follow from IDLE with inputs as applied.
- Latency from an access entering IDLE:
  - 1 IDLE cycle + N WAIT cycles (N ≥ 1; ack on the first WAIT edge gives N = 1) + 1 DONE cycle.
  - Minimum: 3 cycles, 2 of them stalled.
- `dm_req` rises on the edge leaving IDLE and falls on the edge on which ack or timeout is seen. It is never high in DONE.
- Ack and timeout on the same edge: ack wins, no `buserr`.
- Reset during WAIT or DONE: return to IDLE with `dm_req` = 0 next cycle; any ack that follows is ignored.
- Back-to-back accesses: DONE → IDLE, then the new access stalls starting in its IDLE cycle. No accesses overlap.

## Test plan
- Word load at 0x0000_0010, ack on the 3rd WAIT cycle, `dm_rdata` 0x1234_5678:
  - `stallM` high for 4 cycles; `MemoutM` = 0x1234_5678 in DONE.
  - `dm_addr` = 0x10; `dm_be` = 1111.
- Signed byte load at address 0x3, `dm_rdata` 0x80AA_BBCC → `MemoutM` 0xFFFF_FF80. The same access with `memsignM` = 0 → 0x0000_0080.
- Unsigned half load at address 0x2, `dm_rdata` 0xBEEF_0001 → 0x0000_BEEF.
- Store byte 0xAB at address 0x6 → `dm_we` 1, `dm_be` 0100, `dm_wdata` 0xABAB_ABAB, `dm_addr` 0x4; `MemoutM` 0 in DONE.
- Word load at address 0x2 → `alignerr` pulse, `dm_req` stays 0, `regwriteMo` 0, `stallM` 0.
- Two scenarios with `TIMEOUT` = 4:
  - No ack: `buserr` pulses once, `MemoutM` = 0, return to IDLE.
  - Separately, `rst_n` = 0 during WAIT: `dm_req` = 0 next cycle and a late `dm_ack` is ignored.
